// File: rtl/input_cond_pkg.sv
// Shared definitions for the board-input conditioner: per-channel debounce state encoding
// and the channel index map used by the motor-controller front end.
package input_cond_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StPressWait = 2'd1,
        StHeld      = 2'd2,
        StRelWait   = 2'd3
    } chan_state_e;

    localparam int unsigned CH_CHANGE = 0;
    localparam int unsigned CH_MODE   = 1;
    localparam int unsigned CH_MOVE   = 2;
    localparam int unsigned CH_DIR    = 3;
    localparam int unsigned CH_STEP   = 4;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser, polarity normalise, debounce FSM with registered
// level and press/release pulses. Auto-repeat while held is built only with INPUT_REPEAT_EN.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out,
    output logic press_out,
    output logic release_out
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            s;
    chan_state_e     state_q;
    logic [CntW-1:0] cnt_q;
    logic            rpt_fire;

    // Synchroniser resets to the raw de-asserted level so reset release sees no false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {2{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[0], raw_in};
        end
    end

    assign s = sync_q[1] ^ ACTIVE_LOW;

`ifdef INPUT_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax + 1);
    localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

    logic [RptW-1:0] rpt_q;
    logic            repeating_q;

    assign rpt_fire = (state_q == StHeld) && s &&
                      (rpt_q == (repeating_q ? PeriodLast : DelayLast));

    // Counter only runs in HELD; any exit clears it so a re-entry restarts the full delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_q       <= '0;
            repeating_q <= 1'b0;
        end else if (state_q != StHeld) begin
            rpt_q       <= '0;
            repeating_q <= 1'b0;
        end else if (rpt_fire) begin
            rpt_q       <= '0;
            repeating_q <= 1'b1;
        end else begin
            rpt_q <= rpt_q + 1'b1;
        end
    end
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rpt_fire       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            level_out   <= 1'b0;
            press_out   <= 1'b0;
            release_out <= 1'b0;
        end else begin
            press_out   <= 1'b0;
            release_out <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (s) begin
                        state_q <= StPressWait;
                        cnt_q   <= CntW'(1);
                    end
                end
                StPressWait: begin
                    if (!s) begin
                        state_q <= StIdle;
                    end else if (cnt_q == CntLast) begin
                        state_q   <= StHeld;
                        level_out <= 1'b1;
                        press_out <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHeld: begin
                    if (!s) begin
                        state_q <= StRelWait;
                        cnt_q   <= CntW'(1);
                    end else if (rpt_fire) begin
                        press_out <= 1'b1;
                    end
                end
                StRelWait: begin
                    if (s) begin
                        state_q <= StHeld;
                    end else if (cnt_q == CntLast) begin
                        state_q     <= StIdle;
                        level_out   <= 1'b0;
                        release_out <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board-input front end for the stepper-motor controller: N_IN independent debounced channels.
// Optional auto-repeat of press pulses is enabled by defining INPUT_REPEAT_EN.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned N_IN            = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] level_out,
    output logic [N_IN-1:0] press_out,
    output logic [N_IN-1:0] release_out
);

    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .raw_in      (raw_in[i]),
            .level_out   (level_out[i]),
            .press_out   (press_out[i]),
            .release_out (release_out[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce/repeat timings; expectations are
// hand-derived cycle counts from each raw edge.
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int unsigned N_IN = 5;
`ifdef INPUT_REPEAT_EN
    localparam logic RPT         = 1'b1;
    localparam int   EXP_PRESSES = 7;
`else
    localparam logic RPT         = 1'b0;
    localparam int   EXP_PRESSES = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] level_out;
    logic [N_IN-1:0] press_out;
    logic [N_IN-1:0] release_out;

    int errors = 0;
    int checks = 0;

    input_conditioner #(
        .N_IN            (N_IN),
        .DEBOUNCE_CYCLES (8),
        .ACTIVE_LOW      (1'b1),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_in      (raw_in),
        .level_out   (level_out),
        .press_out   (press_out),
        .release_out (release_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [N_IN-1:0] exp_v;
        rst    = 1'b0;
        raw_in = '0;
        tick();
        tick();
        checks++;
        if (level_out !== '0) begin
            errors++; $display("FAIL reset_level: got %b expected 00000", level_out);
        end
        checks++;
        if (press_out !== '0) begin
            errors++; $display("FAIL reset_press: got %b expected 00000", press_out);
        end
        checks++;
        if (release_out !== '0) begin
            errors++; $display("FAIL reset_release: got %b expected 00000", release_out);
        end
        rst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_v = (i == 10) ? '1 : '0;
            checks++;
            if (press_out !== exp_v) begin
                errors++;
                $display("FAIL reset_rel_press t=%0d: got %b expected %b", i, press_out, exp_v);
            end
            exp_v = (i >= 10) ? '1 : '0;
            checks++;
            if (level_out !== exp_v) begin
                errors++;
                $display("FAIL reset_rel_level t=%0d: got %b expected %b", i, level_out, exp_v);
            end
        end
        for (int i = 13; i <= 40; i++) tick();
        checks++;
        if (level_out !== '1) begin
            errors++; $display("FAIL reset_held_level: got %b expected 11111", level_out);
        end
        raw_in = '1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_v = (i == 10) ? '1 : '0;
            checks++;
            if (release_out !== exp_v) begin
                errors++;
                $display("FAIL all_release t=%0d: got %b expected %b", i, release_out, exp_v);
            end
        end
        checks++;
        if (level_out !== '0) begin
            errors++; $display("FAIL all_release_level: got %b expected 00000", level_out);
        end
    endtask

    task automatic test_clean_press();
        raw_in[CH_CHANGE] = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++;
            if (press_out[CH_CHANGE] !== (i == 10)) begin
                errors++;
                $display("FAIL clean_press t=%0d: got %b expected %b",
                         i, press_out[CH_CHANGE], (i == 10));
            end
            checks++;
            if (level_out[CH_CHANGE] !== (i >= 10)) begin
                errors++;
                $display("FAIL clean_level t=%0d: got %b expected %b",
                         i, level_out[CH_CHANGE], (i >= 10));
            end
        end
        for (int i = 15; i <= 30; i++) tick();
        raw_in[CH_CHANGE] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (release_out[CH_CHANGE] !== (i == 10)) begin
                errors++;
                $display("FAIL clean_release t=%0d: got %b expected %b",
                         i, release_out[CH_CHANGE], (i == 10));
            end
        end
    endtask

    task automatic test_bounce();
        raw_in[CH_MOVE] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (press_out[CH_MOVE] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_early t=%0d: got %b expected 0", i, press_out[CH_MOVE]);
            end
        end
        raw_in[CH_MOVE] = 1'b1;
        tick();
        raw_in[CH_MOVE] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (press_out[CH_MOVE] !== (i == 10)) begin
                errors++;
                $display("FAIL bounce_press t=%0d: got %b expected %b",
                         i, press_out[CH_MOVE], (i == 10));
            end
        end
        raw_in[CH_MOVE] = 1'b1;
        for (int i = 1; i <= 12; i++) tick();
        checks++;
        if (level_out[CH_MOVE] !== 1'b0) begin
            errors++; $display("FAIL bounce_released: got %b expected 0", level_out[CH_MOVE]);
        end
    endtask

    task automatic test_release_simul();
        logic [N_IN-1:0] mask;
        logic [N_IN-1:0] exp_v;
        mask          = '0;
        mask[CH_MODE] = 1'b1;
        mask[CH_DIR]  = 1'b1;
        raw_in        = raw_in & ~mask;
        for (int i = 1; i <= 12; i++) tick();
        checks++;
        if ((level_out & mask) !== mask) begin
            errors++;
            $display("FAIL simul_held: got %b expected %b", level_out & mask, mask);
        end
        raw_in = raw_in | mask;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_v = (i == 10) ? mask : '0;
            checks++;
            if ((release_out & mask) !== exp_v) begin
                errors++;
                $display("FAIL simul_release t=%0d: got %b expected %b",
                         i, release_out & mask, exp_v);
            end
            checks++;
            if ((press_out & release_out) !== '0) begin
                errors++;
                $display("FAIL simul_overlap t=%0d: got %b expected 00000",
                         i, press_out & release_out);
            end
        end
    endtask

    task automatic test_reset_mid_held();
        int n_rel;
        raw_in[CH_STEP] = 1'b0;
        for (int i = 1; i <= 12; i++) tick();
        checks++;
        if (level_out[CH_STEP] !== 1'b1) begin
            errors++; $display("FAIL midheld_level: got %b expected 1", level_out[CH_STEP]);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (level_out !== '0) begin
            errors++; $display("FAIL midheld_async: got %b expected 00000", level_out);
        end
        raw_in[CH_STEP] = 1'b1;
        tick();
        tick();
        rst   = 1'b1;
        n_rel = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (release_out[CH_STEP]) n_rel++;
        end
        checks++;
        if (n_rel !== 0) begin
            errors++; $display("FAIL midheld_no_release: got %0d pulses expected 0", n_rel);
        end
        checks++;
        if (level_out[CH_STEP] !== 1'b0) begin
            errors++; $display("FAIL midheld_idle: got %b expected 0", level_out[CH_STEP]);
        end
    endtask

    task automatic test_repeat();
        int n_press;
        int n_late;
        n_press = 0;
        n_late  = 0;
        raw_in[CH_CHANGE] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (press_out[CH_CHANGE]) begin
                n_press++;
                if (i > 60) n_late++;
            end
            if (i == 10 || i == 30) begin
                checks++;
                if (press_out[CH_CHANGE] !== ((i == 10) ? 1'b1 : RPT)) begin
                    errors++;
                    $display("FAIL repeat_pulse t=%0d: got %b expected %b",
                             i, press_out[CH_CHANGE], (i == 10) ? 1'b1 : RPT);
                end
            end
            if (i == 70) begin
                checks++;
                if (release_out[CH_CHANGE] !== 1'b1) begin
                    errors++;
                    $display("FAIL repeat_release: got %b expected 1", release_out[CH_CHANGE]);
                end
            end
            if (i == 60) raw_in[CH_CHANGE] = 1'b1;
        end
        checks++;
        if (n_press !== EXP_PRESSES) begin
            errors++;
            $display("FAIL repeat_count: got %0d expected %0d", n_press, EXP_PRESSES);
        end
        checks++;
        if (n_late !== 0) begin
            errors++; $display("FAIL repeat_after_release: got %0d expected 0", n_late);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_simul();
        test_reset_mid_held();
        test_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
